rst_run_ctrl: RTL
=================

RST_RUN_CTRL -- requirements
Module: rst_run_ctrl

Interface
REQ-001 Parameters SHALL be:
- NCH, 2: number of downstream reset channels (1..8).
- HOLD_CYC, 10: cycles all channels stay in reset after sequence start (>=1).
- STAGGER, 2: cycles between successive channel releases (0 = simultaneous).
- RUN_CYC, 205: run-window length in cycles; 0 = unbounded.
- CW, 32: width of cycle counter.
REQ-002 Ports SHALL be:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse: (re)start the reset/run sequence.
- ext_halt  in  1  level: request end of run window.
- ch_rst  out  NCH  per-channel reset, active-high, bit i drives channel i.
- running  out  1  high while in RUN.
- done  out  1  sticky end-of-run flag.
- cyc_cnt  out  CW  cycles elapsed in current RUN.

Function
REQ-003 FSM states SHALL be HOLD, RELEASE, RUN, DONE; all outputs registered.
REQ-004 HOLD: ch_rst all ones; internal counter counts HOLD_CYC cycles, then -> RELEASE.
REQ-005 RELEASE: channel i deasserts exactly HOLD_CYC + i*STAGGER cycles after HOLD entry; channel 0 first; released channels stay deasserted.
REQ-006 Cycle after last channel (NCH-1) deasserts, state -> RUN; running=1, cyc_cnt=0.
REQ-007 RUN: cyc_cnt increments by 1 per cycle; saturates at all-ones (no wrap).
REQ-008 RUN exits to DONE when cyc_cnt == RUN_CYC-1 (RUN_CYC!=0) or ext_halt=1, whichever first; exit takes effect next edge.
REQ-009 DONE: running=0, done=1, ch_rst all ones, cyc_cnt frozen at final value.
REQ-010 DONE is terminal until start or rst.
REQ-011 start=1 in any state SHALL force HOLD next cycle: ch_rst all ones, done=0, running=0, cyc_cnt=0, hold counter restarts (soft restart, also mid-RELEASE and mid-RUN).
REQ-012 start and ext_halt same cycle: start wins.
REQ-013 ext_halt outside RUN SHALL be ignored.
REQ-014 STAGGER=0: all channels deassert in the same cycle, HOLD_CYC cycles after HOLD entry.
REQ-015 NCH=1: RELEASE lasts zero extra cycles beyond HOLD_CYC.
REQ-016 RUN_CYC=1: RUN lasts exactly one cycle (cyc_cnt=0) before DONE.

Reset
REQ-017 rst=1 SHALL, at next edge, force HOLD with ch_rst all ones, running=0, done=0, cyc_cnt=0, internal counters 0.
REQ-018 rst SHALL dominate start and ext_halt; sequence begins at first edge with rst=0 (counts as HOLD cycle 1).
REQ-019 rst asserted mid-operation SHALL behave identically to REQ-017; no partial state survives.

Verification
REQ-020 Defaults, rst high 10 cycles then low -> ch_rst[0] falls at cycle 10, ch_rst[1] at cycle 12, running rises at 13, done rises 205 cycles later, cyc_cnt=204.
REQ-021 ext_halt pulsed at RUN cycle 50 -> done=1 next cycle, cyc_cnt=50, ch_rst=2'b11.
REQ-022 start pulsed in DONE -> done=0 next cycle, ch_rst=2'b11, full release sequence repeats with identical timing.
REQ-023 start pulsed while ch_rst=2'b10 (mid-RELEASE) -> ch_rst=2'b11 next cycle; channel 0 releases HOLD_CYC cycles after restart.
REQ-024 NCH=4, STAGGER=0, RUN_CYC=0 -> all 4 channels release same cycle; run continues indefinitely until ext_halt; no done without halt.
REQ-025 rst asserted for one cycle mid-RUN -> all outputs return to reset values next edge; sequence restarts from HOLD.

Source files
------------

// File: rtl/rst_run_ctrl.sv
// rst_run_ctrl: reset sequencer and run-window controller.
//
// After a reset or a start pulse, every downstream channel is held in reset for HOLD_CYC
// cycles. The channels are then released one at a time, STAGGER cycles apart, starting with
// channel 0. One cycle after the last release the block enters a run window. The window ends
// after RUN_CYC cycles (never, when RUN_CYC is 0) or earlier on ext_halt. It then parks in a
// sticky DONE state with every channel back in reset.
//
// Ports:
//   clk       in   single clock, rising edge
//   rst       in   synchronous active-high reset
//   start     in   one-cycle pulse, (re)starts the sequence from HOLD
//   ext_halt  in   level, ends the run window (ignored outside RUN)
//   ch_rst    out  [NCH-1:0] per-channel active-high reset
//   running   out  high while in RUN
//   done      out  sticky end-of-run flag
//   cyc_cnt   out  [CW-1:0] cycles elapsed in the current run (saturating)
module rst_run_ctrl #(
    parameter int unsigned NCH      = 2,
    parameter int unsigned HOLD_CYC = 10,
    parameter int unsigned STAGGER  = 2,
    parameter int unsigned RUN_CYC  = 205,
    parameter int unsigned CW       = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           ext_halt,
    output logic [NCH-1:0] ch_rst,
    output logic           running,
    output logic           done,
    output logic [CW-1:0]  cyc_cnt
);

    typedef enum logic [1:0] {StHold, StRelease, StRun, StDone} state_e;

    // Edge (counted from HOLD entry) on which the last channel leaves reset.
    localparam int unsigned LastRel = HOLD_CYC + (NCH - 1) * STAGGER;
    localparam int unsigned HW      = $clog2(LastRel + 1) + 1;
    localparam logic [CW-1:0] RunLast = CW'((RUN_CYC == 0) ? 0 : RUN_CYC - 1);

    state_e           state_q, state_d;
    logic [HW-1:0]    hold_q, hold_d;
    logic [NCH-1:0]   ch_q, ch_d;
    logic             run_q, run_d;
    logic             done_q, done_d;
    logic [CW-1:0]    cyc_q, cyc_d;

    // Channel i is still in reset while the edge count is below its release point.
    function automatic logic [NCH-1:0] ch_mask(input logic [HW-1:0] cnt);
        logic [NCH-1:0] m;
        m = '1;
        for (int unsigned i = 0; i < NCH; i++) begin
            m[i] = (32'(cnt) < (HOLD_CYC + i * STAGGER));
        end
        return m;
    endfunction

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        ch_d    = ch_q;
        run_d   = run_q;
        done_d  = done_q;
        cyc_d   = cyc_q;

        if (start) begin
            // Soft restart from any state; outranks ext_halt.
            state_d = StHold;
            hold_d  = '0;
            ch_d    = '1;
            run_d   = 1'b0;
            done_d  = 1'b0;
            cyc_d   = '0;
        end else begin
            unique case (state_q)
                StHold: begin
                    hold_d = hold_q + HW'(1);
                    ch_d   = ch_mask(hold_d);
                    if (32'(hold_d) >= HOLD_CYC) begin
                        state_d = StRelease;
                    end
                end
                StRelease: begin
                    if (ch_q == '0) begin
                        state_d = StRun;
                        run_d   = 1'b1;
                        cyc_d   = '0;
                    end else begin
                        hold_d = hold_q + HW'(1);
                        ch_d   = ch_mask(hold_d);
                    end
                end
                StRun: begin
                    if (ext_halt || ((RUN_CYC != 0) && (cyc_q == RunLast))) begin
                        state_d = StDone;
                        run_d   = 1'b0;
                        done_d  = 1'b1;
                        ch_d    = '1;
                    end else if (cyc_q != '1) begin
                        cyc_d = cyc_q + CW'(1);
                    end
                end
                StDone: begin
                    // Terminal until start or rst; cyc_cnt keeps its final value.
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StHold;
            hold_q  <= '0;
            ch_q    <= '1;
            run_q   <= 1'b0;
            done_q  <= 1'b0;
            cyc_q   <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            ch_q    <= ch_d;
            run_q   <= run_d;
            done_q  <= done_d;
            cyc_q   <= cyc_d;
        end
    end

    assign ch_rst  = ch_q;
    assign running = run_q;
    assign done    = done_q;
    assign cyc_cnt = cyc_q;

endmodule
